// File: rtl/laser_tx_framer.sv
// Frames packet bytes into the laser on/off symbol stream: a preamble once per packet,
// then each byte as start bit, LSB-first data bits and stop symbol(s), one symbol per bit tick.
module laser_tx_framer #(
    parameter int DATA_BITS     = 8,
    parameter int PREAMBLE_BITS = 8,
    parameter int STOP_BITS     = 1,
    parameter int GAP_TIMEOUT   = 16
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 bit_clk,
    output logic                 div_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_last,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 tx_abort,
    output logic                 laser_out,
    output logic                 busy,
    output logic                 err_underrun,
    output logic [15:0]          frames_sent
);

    localparam int CNT_MAX_A = (PREAMBLE_BITS > DATA_BITS) ? PREAMBLE_BITS : DATA_BITS;
    localparam int CNT_MAX   = (CNT_MAX_A > STOP_BITS) ? CNT_MAX_A : STOP_BITS;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int GAP_W     = $clog2(GAP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        START,
        DATA,
        STOP,
        WAIT_NEXT
    } state_e;

    state_e               state_q, state_d;
    logic                 bit_clk_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 last_q, last_d;
    logic                 laser_q, laser_d;
    logic                 div_en_q, div_en_d;
    logic                 ready_q, ready_d;
    logic                 err_q, err_d;
    logic [15:0]          frames_q, frames_d;

    logic tick;
    logic accept;
    logic timeout;

    assign tick   = bit_clk & ~bit_clk_q;
    assign accept = tx_valid & ready_q;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_clk_q <= 1'b0;
            cnt_q     <= '0;
            gap_q     <= '0;
            shift_q   <= '0;
            last_q    <= 1'b0;
            laser_q   <= 1'b0;
            div_en_q  <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            frames_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_clk_q <= bit_clk;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            shift_q   <= shift_d;
            last_q    <= last_d;
            laser_q   <= laser_d;
            div_en_q  <= div_en_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            frames_q  <= frames_d;
        end
    end

    // In START, cnt_q==0 means the start bit has not been driven yet (entry from WAIT_NEXT).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        shift_d  = shift_q;
        last_d   = last_q;
        laser_d  = laser_q;
        frames_d = frames_q;
        timeout  = 1'b0;
        if (tx_abort) begin
            state_d = IDLE;
            laser_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    laser_d = 1'b0;
                    if (accept) begin
                        state_d = PREAMBLE;
                        cnt_d   = '0;
                        shift_d = tx_data;
                        last_d  = tx_last;
                    end
                end
                PREAMBLE: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(PREAMBLE_BITS)) begin
                            state_d = START;
                            cnt_d   = CNT_W'(1);
                            laser_d = 1'b1;
                        end else begin
                            laser_d = ~cnt_q[0];
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                end
                START: begin
                    if (tick) begin
                        if (cnt_q == '0) begin
                            laser_d = 1'b1;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            state_d = DATA;
                            laser_d = shift_q[0];
                            shift_d = shift_q >> 1;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(DATA_BITS)) begin
                            state_d = STOP;
                            laser_d = 1'b0;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            laser_d = shift_q[0];
                            shift_d = shift_q >> 1;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                end
                STOP: begin
                    laser_d = 1'b0;
                    if (tick) begin
                        if (cnt_q == CNT_W'(STOP_BITS)) begin
                            frames_d = frames_q + 16'd1;
                            state_d  = last_q ? IDLE : WAIT_NEXT;
                            gap_d    = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                WAIT_NEXT: begin
                    laser_d = 1'b0;
                    if (accept) begin
                        state_d = START;
                        cnt_d   = '0;
                        shift_d = tx_data;
                        last_d  = tx_last;
                    end else if (tick) begin
                        if (gap_q == GAP_W'(GAP_TIMEOUT - 1)) begin
                            state_d = IDLE;
                            timeout = 1'b1;
                        end else begin
                            gap_d = gap_q + GAP_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    laser_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        div_en_d = (state_d != IDLE);
        ready_d  = ((state_d == IDLE) || (state_d == WAIT_NEXT)) && !tx_abort;
        err_d    = timeout;
    end

    assign laser_out    = laser_q;
    assign div_en       = div_en_q;
    assign tx_ready     = ready_q;
    assign err_underrun = err_q;
    assign frames_sent  = frames_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_laser_tx_framer.sv
// Self-checking bench for laser_tx_framer: divider model, symbol scoreboard fed on accept,
// a table of single-byte packets and hand-written multi-cycle corner cases.
module tb_laser_tx_framer;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b0;
    logic        bit_clk  = 1'b0;
    logic        div_en;
    logic [7:0]  tx_data  = 8'h00;
    logic        tx_last  = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        tx_abort = 1'b0;
    logic        laser_out;
    logic        busy;
    logic        err_underrun;
    logic [15:0] frames_sent;

    int compared   = 0;
    int mismatched = 0;
    int errPulses  = 0;

    logic       sbQ[$];
    logic [1:0] divCnt     = 2'd0;
    logic       bitClkPrev = 1'b0;
    logic       tickNow;
    logic       expSym;
    logic       tickPending;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] expFrames;
    } vec_t;

    vec_t vecs[4];

    laser_tx_framer dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .bit_clk      (bit_clk),
        .div_en       (div_en),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_abort     (tx_abort),
        .laser_out    (laser_out),
        .busy         (busy),
        .err_underrun (err_underrun),
        .frames_sent  (frames_sent)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Divider model: bit_clk toggles every 4 cycles while enabled, held low otherwise.
    always @(posedge CLOCK_50) begin
        if (!div_en) begin
            bit_clk <= 1'b0;
            divCnt  <= 2'd0;
        end else if (divCnt == 2'd3) begin
            bit_clk <= ~bit_clk;
            divCnt  <= 2'd0;
        end else begin
            divCnt <= divCnt + 2'd1;
        end
    end

    // High at a negedge when the following posedge will see a bit tick.
    assign tickPending = bit_clk && !bitClkPrev;

    always @(negedge CLOCK_50) begin
        if (err_underrun) errPulses++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Each sampled tick pops the next expected symbol; with nothing queued the laser must be off.
    always @(posedge CLOCK_50) begin
        tickNow = bit_clk && !bitClkPrev;
        bitClkPrev <= bit_clk;
        if (tickNow && reset) begin
            #1;
            if (sbQ.size() > 0) begin
                expSym = sbQ.pop_front();
                checkOutput("laserSym", {31'd0, laser_out}, {31'd0, expSym});
            end else begin
                checkOutput("idleSym", {31'd0, laser_out}, 32'd0);
            end
        end
    end

    task automatic pushFrame(input logic [7:0] d, input bit withPreamble);
        if (withPreamble)
            for (int i = 0; i < 8; i++) sbQ.push_back((i % 2) == 0);
        sbQ.push_back(1'b1);
        for (int i = 0; i < 8; i++) sbQ.push_back(d[i]);
        sbQ.push_back(1'b0);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic applyStimulus(input logic [7:0] d, input logic last, input bit withPreamble);
        int budget;
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        budget   = 600;
        while (!tx_ready && budget > 0) begin
            @(negedge CLOCK_50);
            budget--;
        end
        if (!tx_ready) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
            tx_valid = 1'b0;
            return;
        end
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        pushFrame(d, withPreamble);
        tx_valid = 1'b0;
        tx_data  = ~d;
        tx_last  = 1'b0;
        checkOutput("readyFall", {31'd0, tx_ready}, 32'd0);
    endtask

    task automatic waitIdle();
        int budget = 600;
        @(negedge CLOCK_50);
        while ((busy || sbQ.size() != 0) && budget > 0) begin
            @(negedge CLOCK_50);
            budget--;
        end
        checkOutput("idleReached", {31'd0, busy}, 32'd0);
        checkOutput("sbDrained", sbQ.size(), 32'd0);
    endtask

    task automatic waitFrames(input logic [15:0] target);
        int budget = 600;
        @(negedge CLOCK_50);
        while (frames_sent != target && budget > 0) begin
            @(negedge CLOCK_50);
            budget--;
        end
        checkOutput("framesReached", {16'd0, frames_sent}, {16'd0, target});
    endtask

    task automatic waitTicks(input int n);
        int budget;
        for (int k = 0; k < n; k++) begin
            budget = 50;
            @(negedge CLOCK_50);
            while (!tickPending && budget > 0) begin
                @(negedge CLOCK_50);
                budget--;
            end
            if (!tickPending) checkOutput("tickTimeout", 32'd0, 32'd1);
        end
    endtask

    task automatic doReset();
        @(negedge CLOCK_50);
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_abort = 1'b0;
        sbQ.delete();
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        checkOutput("readyAfterReset", {31'd0, tx_ready}, 32'd1);
        @(negedge CLOCK_50);
    endtask

    initial begin
        int errBase;
        int ticksSeen;
        int errAt;

        vecs[0] = '{data: 8'hA5, expFrames: 16'd1};
        vecs[1] = '{data: 8'h00, expFrames: 16'd2};
        vecs[2] = '{data: 8'hFF, expFrames: 16'd3};
        vecs[3] = '{data: 8'h81, expFrames: 16'd4};

        repeat (3) @(negedge CLOCK_50);
        checkOutput("rstLaser", {31'd0, laser_out}, 32'd0);
        checkOutput("rstDivEn", {31'd0, div_en}, 32'd0);
        checkOutput("rstReady", {31'd0, tx_ready}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstErr", {31'd0, err_underrun}, 32'd0);
        checkOutput("rstFrames", {16'd0, frames_sent}, 32'd0);
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        checkOutput("readyAfterReset", {31'd0, tx_ready}, 32'd1);
        @(negedge CLOCK_50);

        $display("[TB] single-byte packet table");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].data, 1'b1, 1'b1);
            waitIdle();
            checkOutput("tblFrames", {16'd0, frames_sent}, {16'd0, vecs[i].expFrames});
            checkOutput("tblDivEnOff", {31'd0, div_en}, 32'd0);
            checkOutput("tblReadyIdle", {31'd0, tx_ready}, 32'd1);
        end

        $display("[TB] two-byte packet, valid held");
        doReset();
        applyStimulus(8'h01, 1'b0, 1'b1);
        applyStimulus(8'h80, 1'b1, 1'b0);
        waitIdle();
        checkOutput("twoByteFrames", {16'd0, frames_sent}, 32'd2);

        $display("[TB] gap timeout");
        doReset();
        applyStimulus(8'h3C, 1'b0, 1'b1);
        waitFrames(16'd1);
        errBase   = errPulses;
        ticksSeen = 0;
        errAt     = -1;
        repeat (200) begin
            @(negedge CLOCK_50);
            if (err_underrun && errAt < 0) errAt = ticksSeen;
            if (tickPending) ticksSeen++;
        end
        checkOutput("underrunCount", errPulses - errBase, 32'd1);
        checkOutput("underrunTick", errAt, 32'd16);
        checkOutput("underrunBusy", {31'd0, busy}, 32'd0);
        checkOutput("underrunDivEn", {31'd0, div_en}, 32'd0);
        checkOutput("underrunLaser", {31'd0, laser_out}, 32'd0);
        checkOutput("underrunFrames", {16'd0, frames_sent}, 32'd1);

        $display("[TB] accept on the timeout tick");
        doReset();
        applyStimulus(8'h96, 1'b0, 1'b1);
        waitFrames(16'd1);
        errBase = errPulses;
        waitTicks(16);
        applyStimulus(8'hC3, 1'b1, 1'b0);
        waitIdle();
        checkOutput("edgeAcceptNoErr", errPulses - errBase, 32'd0);
        checkOutput("edgeAcceptFrames", {16'd0, frames_sent}, 32'd2);

        $display("[TB] abort during data");
        doReset();
        errBase = errPulses;
        applyStimulus(8'hFF, 1'b1, 1'b1);
        waitTicks(12);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        tx_abort = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        tx_last  = 1'b1;
        @(posedge CLOCK_50);
        #1;
        checkOutput("abortLaser", {31'd0, laser_out}, 32'd0);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortDivEn", {31'd0, div_en}, 32'd0);
        checkOutput("abortFrames", {16'd0, frames_sent}, 32'd0);
        checkOutput("abortReady", {31'd0, tx_ready}, 32'd0);
        @(negedge CLOCK_50);
        @(posedge CLOCK_50);
        #1;
        checkOutput("abortHeldReady", {31'd0, tx_ready}, 32'd0);
        checkOutput("abortHeldBusy", {31'd0, busy}, 32'd0);
        @(negedge CLOCK_50);
        tx_abort = 1'b0;
        tx_valid = 1'b0;
        sbQ.delete();
        @(posedge CLOCK_50);
        #1;
        checkOutput("abortReleaseReady", {31'd0, tx_ready}, 32'd1);
        checkOutput("abortNoErr", errPulses - errBase, 32'd0);
        @(negedge CLOCK_50);
        applyStimulus(8'h5A, 1'b1, 1'b1);
        waitIdle();
        checkOutput("afterAbortFrames", {16'd0, frames_sent}, 32'd1);

        $display("[TB] reset mid-preamble");
        applyStimulus(8'h42, 1'b1, 1'b1);
        waitTicks(3);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        sbQ.delete();
        #1;
        checkOutput("midRstLaser", {31'd0, laser_out}, 32'd0);
        checkOutput("midRstDivEn", {31'd0, div_en}, 32'd0);
        checkOutput("midRstReady", {31'd0, tx_ready}, 32'd0);
        checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("midRstErr", {31'd0, err_underrun}, 32'd0);
        checkOutput("midRstFrames", {16'd0, frames_sent}, 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        checkOutput("readyBeforeEdge", {31'd0, tx_ready}, 32'd0);
        @(posedge CLOCK_50);
        #1;
        checkOutput("readyAfterRelease", {31'd0, tx_ready}, 32'd1);

        repeat (4) @(negedge CLOCK_50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        mismatched++;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
